precomp_nibble_mac: RTL and testbench
=====================================

Name: precomp_nibble_mac

Overview:
- Consumer side of the odd-multiple precomputer bank in the FIR datapath.
- Accepts the eight precomputed odd multiples of one data sample (x1, x3 … x15) plus one coefficient.
- Computes sample × coefficient serially, one 4-bit coefficient nibble per clock, with select-and-shift: no multiplier.
- Returns the full-width product over a valid/ready handshake, ready for the tap accumulator.

Parameters:
- IN_DATA_WIDTH, 17, width of the raw unsigned sample the bank was built from.
- OUT_DATA_WIDTH, 21, width of each bank multiple x1..x15.
- COEF_WIDTH, 16, unsigned coefficient width; must be a multiple of 4.
- ACC_WIDTH, IN_DATA_WIDTH+COEF_WIDTH (33), product/accumulator width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- x1,x3,x5,x7,x9,x11,x13,x15  in  OUT_DATA_WIDTH each  odd-multiple bank of the current sample.
- coeff  in  COEF_WIDTH  unsigned coefficient.
- in_valid  in  1  bank+coeff valid.
- in_ready  out  1  block can accept an operand set.
- result  out  ACC_WIDTH  unsigned product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, nibble index=0, accumulator=0, latched operands=0.
- NIBBLES = COEF_WIDTH/4 (4 by default).
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch all eight multiples and coeff, clear accumulator, idx=0, go to RUN.
  - RUN: in_ready=0. Each edge: acc <= acc + (pp(nib[idx]) << 4*idx), idx <= idx+1. The edge that processes idx=NIBBLES-1 goes to DONE.
  - DONE: out_valid=1, result=acc, held stable. On out_ready go to IDLE next edge, out_valid drops.
- Latency: accept edge E0. Nibbles are processed on E1..E_NIBBLES. out_valid is high after E_NIBBLES (4 cycles after accept).
- Throughput: minimum one operation per NIBBLES+2 cycles, including one DONE cycle and one IDLE cycle. in_ready is low in RUN and DONE; in_valid there is ignored and nothing is latched.
- Nibble decode pp(n), width OUT_DATA_WIDTH+3:
  - 0→0; 1→x1; 2→x1<<1; 3→x3; 4→x1<<2; 5→x5; 6→x3<<1; 7→x7; 8→x1<<3.
  - 9→x9; 10→x5<<1; 11→x11; 12→x3<<2; 13→x13; 14→x7<<1; 15→x15.
- Arithmetic: unsigned; partial products zero-extended to ACC_WIDTH before the shift. Sum truncated to ACC_WIDTH; no overflow is possible for a consistent bank.
- Bank consistency: the bank is trusted, with no check that x3 equals 3*x1 and so on.
- Operand stability: operands are latched at accept, so upstream may change x*/coeff immediately after the handshake.
- Zero-nibble coefficient: all four nibble cycles still run; latency is fixed and data-independent.
- out_ready held high: DONE lasts exactly one cycle.
- out_ready low: result and out_valid hold indefinitely and the FSM stays in DONE.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and out_valid is 0 in the same cycle.

Test Plan:
- Basic: sample 1000 (x1=1000 … x15=15000), coeff=0x1234, out_ready=1 → out_valid 4 cycles after accept, result=4660000, in_ready low for 5 cycles total.
- Max corner: sample 131071 with full bank, coeff=0xFFFF → result=8589737985; no truncation in a 33-bit result.
- Every decode: sample 3, coeff=0xF0A2 → result=184806. Then sample 1 with coeff 0x1111 … 0xFFFF, checking result=coeff for each; 0 → result 0 with the same 4-cycle latency.
- Backpressure: result ready with out_ready=0 for 10 cycles while in_valid toggles → result stable, out_valid stays 1, in_ready stays 0, no new accept. out_ready=1 → IDLE, next operand accepted.
- Operand change after accept: change x* and coeff the cycle after the handshake → result uses the latched values.
- Async reset: assert rst during RUN at idx=2 (between edges) → out_valid=0 and in_ready=1 immediately. After release, a new op 5×7 → result=35.

Source files
------------

// File: rtl/precomp_nibble_mac.sv
// -----------------------------------------------------------------------------
// precomp_nibble_mac
//
// Purpose:
//   Consumer of the odd-multiple precomputer bank in the FIR datapath.
//   It multiplies one data sample by an unsigned coefficient without a
//   multiplier. Each clock it takes one 4-bit coefficient nibble, picks the
//   matching multiple of the sample out of the bank (x1..x15, shifted left
//   where the nibble is even), and adds it into the accumulator at weight
//   16^idx. The product is ready NIBBLES cycles after the operands are accepted.
//
// Handshake (valid/ready, both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The producer holds valid and data steady until that edge.
//   in_ready is high only in IDLE. out_valid is high only in DONE. In DONE,
//   result is held until out_ready is seen.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   x1..x15    odd-multiple bank of the current sample (OUT_DATA_WIDTH each)
//   coeff      unsigned coefficient (COEF_WIDTH, a multiple of 4)
//   in_valid   bank + coeff valid
//   in_ready   block can accept an operand set
//   result     unsigned product (ACC_WIDTH)
//   out_valid  result valid
//   out_ready  downstream accepts result
// -----------------------------------------------------------------------------
module precomp_nibble_mac #(
    parameter int IN_DATA_WIDTH  = 17,
    parameter int OUT_DATA_WIDTH = 21,
    parameter int COEF_WIDTH     = 16,
    parameter int ACC_WIDTH      = IN_DATA_WIDTH + COEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OUT_DATA_WIDTH-1:0] x1,
    input  logic [OUT_DATA_WIDTH-1:0] x3,
    input  logic [OUT_DATA_WIDTH-1:0] x5,
    input  logic [OUT_DATA_WIDTH-1:0] x7,
    input  logic [OUT_DATA_WIDTH-1:0] x9,
    input  logic [OUT_DATA_WIDTH-1:0] x11,
    input  logic [OUT_DATA_WIDTH-1:0] x13,
    input  logic [OUT_DATA_WIDTH-1:0] x15,
    input  logic [COEF_WIDTH-1:0]     coeff,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ACC_WIDTH-1:0]      result,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int NIBBLES  = COEF_WIDTH / 4;
    localparam int PP_WIDTH = OUT_DATA_WIDTH + 3;
    localparam int IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [ACC_WIDTH-1:0]      acc;

    // Operands are latched at accept, so upstream is free to move on.
    logic [OUT_DATA_WIDTH-1:0] m1_q, m3_q, m5_q, m7_q, m9_q, m11_q, m13_q, m15_q;
    logic [COEF_WIDTH-1:0]     coeff_q;

    logic [3:0]                nib;
    logic [PP_WIDTH-1:0]       pp;
    logic [ACC_WIDTH-1:0]      pp_shifted;
    logic [ACC_WIDTH-1:0]      acc_sum;
    logic                      last_nib;

    // Current nibble, least significant first.
    assign nib = coeff_q[{idx, 2'b00} +: 4];

    // Select-and-shift decode. An even nibble is an odd multiple shifted left:
    // n = odd * 2^k, so pp = x_odd << k. The three spare bits of PP_WIDTH
    // leave room for the largest shift (x1 << 3).
    always_comb begin
        pp = '0;
        case (nib)
            4'd0:  pp = '0;
            4'd1:  pp = {3'b000, m1_q};
            4'd2:  pp = {3'b000, m1_q} << 1;
            4'd3:  pp = {3'b000, m3_q};
            4'd4:  pp = {3'b000, m1_q} << 2;
            4'd5:  pp = {3'b000, m5_q};
            4'd6:  pp = {3'b000, m3_q} << 1;
            4'd7:  pp = {3'b000, m7_q};
            4'd8:  pp = {3'b000, m1_q} << 3;
            4'd9:  pp = {3'b000, m9_q};
            4'd10: pp = {3'b000, m5_q} << 1;
            4'd11: pp = {3'b000, m11_q};
            4'd12: pp = {3'b000, m3_q} << 2;
            4'd13: pp = {3'b000, m13_q};
            4'd14: pp = {3'b000, m7_q} << 1;
            4'd15: pp = {3'b000, m15_q};
            default: pp = '0;
        endcase
    end

    // Zero-extend to the accumulator width before weighting by 16^idx.
    // The sum is truncated to ACC_WIDTH. A consistent bank cannot overflow.
    assign pp_shifted = ACC_WIDTH'(pp) << {idx, 2'b00};
    assign acc_sum    = acc + pp_shifted;
    assign last_nib   = (idx == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            idx       <= '0;
            acc       <= '0;
            m1_q      <= '0;
            m3_q      <= '0;
            m5_q      <= '0;
            m7_q      <= '0;
            m9_q      <= '0;
            m11_q     <= '0;
            m13_q     <= '0;
            m15_q     <= '0;
            coeff_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m1_q     <= x1;
                        m3_q     <= x3;
                        m5_q     <= x5;
                        m7_q     <= x7;
                        m9_q     <= x9;
                        m11_q    <= x11;
                        m13_q    <= x13;
                        m15_q    <= x15;
                        coeff_q  <= coeff;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                // All nibbles run even when they are zero. This keeps the
                // latency fixed and independent of the data.
                RUN: begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                    if (last_nib) begin
                        result    <= acc_sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_precomp_nibble_mac.sv
// -----------------------------------------------------------------------------
// tb_precomp_nibble_mac
//
// Drives directed operand sets into precomp_nibble_mac. The driver pushes the
// hand-computed product into exp_q when an operand set is accepted. A monitor
// pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_precomp_nibble_mac;

    localparam int IN_W  = 17;
    localparam int OUT_W = 21;
    localparam int CW    = 16;
    localparam int AW    = IN_W + CW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [OUT_W-1:0] x1, x3, x5, x7, x9, x11, x13, x15;
    logic [CW-1:0]    coeff;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    result;
    logic             out_valid;
    logic             out_ready;

    precomp_nibble_mac #(
        .IN_DATA_WIDTH (IN_W),
        .OUT_DATA_WIDTH(OUT_W),
        .COEF_WIDTH    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x1       (x1),
        .x3       (x3),
        .x5       (x5),
        .x7       (x7),
        .x9       (x9),
        .x11      (x11),
        .x13      (x13),
        .x15      (x15),
        .coeff    (coeff),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d, expected no output (t=%0t)", result, $time);
            end else begin
                check("result", 64'(result), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_bank(input logic [31:0] s, input logic [CW-1:0] c);
        x1    = OUT_W'(s * 1);
        x3    = OUT_W'(s * 3);
        x5    = OUT_W'(s * 5);
        x7    = OUT_W'(s * 7);
        x9    = OUT_W'(s * 9);
        x11   = OUT_W'(s * 11);
        x13   = OUT_W'(s * 13);
        x15   = OUT_W'(s * 15);
        coeff = c;
    endtask

    // Issue one operation. If scramble is set, the inputs are changed right
    // after the accept edge.
    task automatic do_op(input logic [31:0] s, input logic [CW-1:0] c,
                         input logic [AW-1:0] exp_val, input bit scramble);
        int n;
        int lat;
        @(negedge clk);
        set_bank(s, c);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed %0d, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(exp_val);
        #1;
        in_valid = 1'b0;
        if (scramble) set_bank($urandom_range(1, 131071), CW'($urandom_range(1, 65535)));
        check("in_ready_low_after_accept", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat < 4) check("in_ready_low_in_run", 64'(in_ready), 64'd0);
        end
        check("latency", 64'(lat), 64'd4);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check("out_valid_one_cycle", 64'(out_valid), 64'd0);
            check("in_ready_back", 64'(in_ready), 64'd1);
            check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [CW-1:0] c;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_bank(0, '0);
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic
        do_op(1000, 16'h1234, 33'd4660000, 1'b0);
        // Max corner: no truncation in the 33-bit result
        do_op(131071, 16'hFFFF, 33'd8589737985, 1'b0);
        // Decodes of F, 0, A, 2
        do_op(3, 16'hF0A2, 33'd184806, 1'b0);
        // Every nibble value with sample 1: result equals the coefficient
        for (int k = 1; k < 16; k++) begin
            c = CW'(k * 16'h1111);
            do_op(1, c, AW'(c), 1'b0);
        end
        // Zero coefficient, same fixed latency
        do_op(12345, 16'h0000, 33'd0, 1'b0);
        // Operands change right after accept
        do_op(1000, 16'h1234, 33'd4660000, 1'b1);

        // Backpressure: out_ready low for 10 cycles while in_valid toggles
        out_ready = 1'b0;
        do_op(1234, 16'h0100, 33'd315904, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            set_bank($urandom_range(1, 131071), CW'($urandom_range(1, 65535)));
            check("bp_result_hold", 64'(result), 64'd315904);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        do_op(7, 16'h0009, 33'd63, 1'b0);

        // Async reset during RUN with idx=2
        @(negedge clk);
        set_bank(1000, 16'h1234);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(5, 16'h0007, 33'd35, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
